// File: rtl/apb_i2c_bridge.sv
// APB register front-end for the I2C master: control regs, start handshake, TX/RX byte FIFOs.
// Optional interrupt output and enables are built when APB_I2C_IRQ_EN is defined.
module apb_i2c_bridge #(
    parameter int DEPTH = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i2c_reset_n,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] paddr,
    input  logic [31:0]   pwdata,
    output logic [31:0]   prdata,
    output logic          pready,
    output logic          pslverr,
    output logic          i2c_enable,
    output logic [6:0]    i2c_addr,
    output logic          i2c_rw,
    output logic          i2c_repeat_start,
    output logic [7:0]    i2c_data_in,
    input  logic          i2c_ready,
    input  logic [7:0]    i2c_data_out,
    input  logic          fifo_tx_rd_en,
    input  logic          fifo_rx_wr_en
`ifdef APB_I2C_IRQ_EN
    ,
    output logic          irq
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ST_IDLE, ST_REQ} state_t;

    state_t        state_q, state_d;
    logic [6:0]    addr_q;
    logic          rw_q, rep_q;
    logic [1:0]    ie_bits;
    logic [7:0]    tx_mem [DEPTH];
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic          tx_ovf_q, rx_ovf_q, tx_rd_en_q, rx_wr_en_q;

    logic acc, wr, rd, ctrl_wr, stat_wr, txd_wr, rxd_rd, start_ok;
    logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop;
    logic unused_ok;

    assign acc      = psel & penable;
    assign wr       = acc & pwrite;
    assign rd       = acc & ~pwrite;
    assign ctrl_wr  = wr & (paddr[3:2] == 2'd0);
    assign stat_wr  = wr & (paddr[3:2] == 2'd1);
    assign txd_wr   = wr & (paddr[3:2] == 2'd2);
    assign rxd_rd   = rd & (paddr[3:2] == 2'd3);
    assign start_ok = ctrl_wr & pwdata[0] & (state_q == ST_IDLE) & i2c_ready;

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == CW'(DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == CW'(DEPTH));

    // Strobes from the master are levels; only their first cycle moves a pointer.
    assign tx_push = txd_wr & ~tx_full;
    assign tx_pop  = fifo_tx_rd_en & ~tx_rd_en_q & ~tx_empty;
    assign rx_push = fifo_rx_wr_en & ~rx_wr_en_q & ~rx_full;
    assign rx_pop  = rxd_rd & ~rx_empty;

    assign pready    = 1'b1;
    assign unused_ok = ^{paddr, pwdata};

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok)   state_d = ST_REQ;
            ST_REQ:  if (!i2c_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        i2c_enable = (state_q == ST_REQ);
    end

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push & ~tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
        else if (tx_pop & ~tx_push) tx_cnt_d = tx_cnt_q - CW'(1);
        rx_cnt_d = rx_cnt_q;
        if (rx_push & ~rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
        else if (rx_pop & ~rx_push) rx_cnt_d = rx_cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            addr_q     <= '0;
            rw_q       <= 1'b0;
            rep_q      <= 1'b0;
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
            tx_rd_en_q <= 1'b0;
            rx_wr_en_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                addr_q <= pwdata[14:8];
                rw_q   <= pwdata[1];
                rep_q  <= pwdata[2];
            end
            if (tx_push) tx_wp_q <= tx_wp_q + PW'(1);
            if (tx_pop)  tx_rp_q <= tx_rp_q + PW'(1);
            if (rx_push) rx_wp_q <= rx_wp_q + PW'(1);
            if (rx_pop)  rx_rp_q <= rx_rp_q + PW'(1);
            tx_cnt_q   <= tx_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            // A fresh overflow wins over a simultaneous W1C.
            tx_ovf_q   <= (tx_ovf_q & ~(stat_wr & pwdata[5])) | (txd_wr & tx_full);
            rx_ovf_q   <= (rx_ovf_q & ~(stat_wr & pwdata[6])) | (fifo_rx_wr_en & ~rx_wr_en_q & rx_full);
            tx_rd_en_q <= fifo_tx_rd_en;
            rx_wr_en_q <= fifo_rx_wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q] <= pwdata[7:0];
        if (rx_push) rx_mem[rx_wp_q] <= i2c_data_out;
    end

`ifdef APB_I2C_IRQ_EN
    logic [1:0] ie_q;
    logic       irq_q;

    always_ff @(posedge clk or negedge i2c_reset_n) begin
        if (!i2c_reset_n) begin
            ie_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= pwdata[17:16];
            irq_q <= (ie_q[0] & tx_empty) | (ie_q[1] & ~rx_empty) | tx_ovf_q | rx_ovf_q;
        end
    end
    assign ie_bits = ie_q;
    assign irq     = irq_q;
`else
    assign ie_bits = 2'b00;
`endif

    assign i2c_addr         = addr_q;
    assign i2c_rw           = rw_q;
    assign i2c_repeat_start = rep_q;
    assign i2c_data_in      = tx_empty ? 8'h00 : tx_mem[tx_rp_q];

    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (rd) begin
            case (paddr[3:2])
                2'd0: prdata = {14'b0, ie_bits, 1'b0, addr_q, 5'b0, rep_q, rw_q, 1'b0};
                2'd1: prdata = {8'b0, 8'(rx_cnt_q), 8'(tx_cnt_q), 1'b0, rx_ovf_q, tx_ovf_q,
                                rx_full, rx_empty, tx_full, tx_empty, i2c_ready};
                2'd3: prdata = rx_empty ? 32'h0 : {24'b0, rx_mem[rx_rp_q]};
                default: prdata = '0;
            endcase
        end
        if (acc) begin
            pslverr = (ctrl_wr & pwdata[0] & ~((state_q == ST_IDLE) & i2c_ready))
                    | (txd_wr & tx_full) | (rxd_rd & rx_empty);
        end
    end
endmodule

// File: tb/tb_apb_i2c_bridge.sv
// Directed test of apb_i2c_bridge: registers, start handshake, TX/RX FIFOs, reset, optional irq.
module tb_apb_i2c_bridge;
    logic        clk = 1'b0;
    logic        i2c_reset_n;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, i2c_enable, i2c_rw, i2c_repeat_start;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data_in, i2c_data_out;
    logic        i2c_ready, fifo_tx_rd_en, fifo_rx_wr_en;
`ifdef APB_I2C_IRQ_EN
    logic        irq;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] rdat;
    logic        err;

    always #5 clk = ~clk;

    apb_i2c_bridge #(.DEPTH(8), .AW(4)) dut (
        .clk(clk), .i2c_reset_n(i2c_reset_n),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .i2c_enable(i2c_enable), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
        .i2c_repeat_start(i2c_repeat_start), .i2c_data_in(i2c_data_in),
        .i2c_ready(i2c_ready), .i2c_data_out(i2c_data_out),
        .fifo_tx_rd_en(fifo_tx_rd_en), .fifo_rx_wr_en(fifo_rx_wr_en)
`ifdef APB_I2C_IRQ_EN
        , .irq(irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [3:0] a, input logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        #1 e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        $display("apb wr addr=%h data=%h slverr=%0b", a, d, e);
    endtask

    task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clk);
        penable = 1'b1;
        #1 d = prdata; e = pslverr;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        $display("apb rd addr=%h data=%h slverr=%0b", a, d, e);
    endtask

    task automatic tx_strobe(input int n);
        @(negedge clk);
        fifo_tx_rd_en = 1'b1;
        repeat (n) @(negedge clk);
        fifo_tx_rd_en = 1'b0;
        $display("tx strobe %0d cycles", n);
    endtask

    task automatic rx_strobe(input logic [7:0] d, input int n);
        @(negedge clk);
        i2c_data_out  = d;
        fifo_rx_wr_en = 1'b1;
        repeat (n) @(negedge clk);
        fifo_rx_wr_en = 1'b0;
        $display("rx strobe data=%h %0d cycles", d, n);
    endtask

    initial begin
        i2c_reset_n = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        i2c_ready = 1'b1; i2c_data_out = '0; fifo_tx_rd_en = 0; fifo_rx_wr_en = 0;
        #1;
        chk("rst_enable", {31'b0, i2c_enable}, 32'h0);
        chk("rst_data_in", {24'b0, i2c_data_in}, 32'h0);
        chk("rst_pready", {31'b0, pready}, 32'h1);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_slverr", {31'b0, pslverr}, 32'h0);
        chk("rst_addr", {25'b0, i2c_addr}, 32'h0);
        repeat (3) @(negedge clk);
        i2c_reset_n = 1'b1;

        apb_read(4'h4, rdat, err);
        chk("status_reset", rdat, 32'h0000_000B);

        // TX show-ahead and single pop on a long strobe
        apb_write(4'h8, 32'hA5, err);
        chk("txw1_err", {31'b0, err}, 32'h0);
        apb_write(4'h8, 32'h3C, err);
        chk("tx_head_a5", {24'b0, i2c_data_in}, 32'hA5);
        apb_read(4'h4, rdat, err);
        chk("status_tx2", rdat, 32'h0000_0209);
        tx_strobe(5);
        chk("tx_head_3c", {24'b0, i2c_data_in}, 32'h3C);
        apb_read(4'h4, rdat, err);
        chk("status_tx1", rdat, 32'h0000_0109);
        tx_strobe(1);
        tx_strobe(1);
        chk("tx_empty_data", {24'b0, i2c_data_in}, 32'h0);
        apb_read(4'h4, rdat, err);
        chk("status_tx0", rdat, 32'h0000_000B);

        // TX overflow and W1C
        for (int i = 0; i < 8; i++) begin
            apb_write(4'h8, 32'(i + 1), err);
            chk("txfill_err", {31'b0, err}, 32'h0);
        end
        apb_write(4'h8, 32'hEE, err);
        chk("txovf_err", {31'b0, err}, 32'h1);
        apb_read(4'h4, rdat, err);
        chk("status_txfull", rdat, 32'h0000_082D);
        apb_write(4'h4, 32'h20, err);
        apb_read(4'h4, rdat, err);
        chk("status_w1c", rdat, 32'h0000_080D);
        for (int i = 0; i < 8; i++) begin
            chk("tx_drain", {24'b0, i2c_data_in}, 32'(i + 1));
            tx_strobe(1);
        end
        chk("tx_drained", {24'b0, i2c_data_in}, 32'h0);

        // Start handshake
        apb_write(4'h0, 32'h0000_5001, err);
        chk("start_err", {31'b0, err}, 32'h0);
        chk("start_enable", {31'b0, i2c_enable}, 32'h1);
        chk("start_addr", {25'b0, i2c_addr}, 32'h50);
        chk("start_rw", {31'b0, i2c_rw}, 32'h0);
        apb_read(4'h0, rdat, err);
        chk("ctrl_read", rdat, 32'h0000_5000);
        apb_write(4'h0, 32'h0000_5001, err);
        chk("start_in_req_err", {31'b0, err}, 32'h1);
        @(negedge clk);
        i2c_ready = 1'b0;
        @(negedge clk);
        chk("enable_drop", {31'b0, i2c_enable}, 32'h0);
        apb_write(4'h0, 32'h0000_3307, err);
        chk("start_busy_err", {31'b0, err}, 32'h1);
        chk("busy_enable", {31'b0, i2c_enable}, 32'h0);
        chk("busy_addr", {25'b0, i2c_addr}, 32'h33);
        chk("busy_rw", {31'b0, i2c_rw}, 32'h1);
        chk("busy_rep", {31'b0, i2c_repeat_start}, 32'h1);
        apb_read(4'h4, rdat, err);
        chk("status_busy", rdat, 32'h0000_000A);
        i2c_ready = 1'b1;
        apb_write(4'h0, 32'h0003_0000, err);
        apb_read(4'h0, rdat, err);
`ifdef APB_I2C_IRQ_EN
        chk("ctrl_ie", rdat, 32'h0003_0000);
`else
        chk("ctrl_ie", rdat, 32'h0000_0000);
`endif

        // RX push, pop, underflow
        rx_strobe(8'h7E, 3);
        apb_read(4'h4, rdat, err);
        chk("status_rx1", rdat, 32'h0001_0003);
        apb_read(4'hC, rdat, err);
        chk("rx_data", rdat, 32'h7E);
        chk("rx_err", {31'b0, err}, 32'h0);
        apb_read(4'hC, rdat, err);
        chk("rx_empty_data", rdat, 32'h0);
        chk("rx_empty_err", {31'b0, err}, 32'h1);

        // RX overflow, drain in order, W1C
        for (int i = 0; i < 9; i++) rx_strobe(8'(8'h10 + i), 1);
        apb_read(4'h4, rdat, err);
        chk("status_rxfull", rdat, 32'h0008_0053);
        for (int i = 0; i < 8; i++) begin
            apb_read(4'hC, rdat, err);
            chk("rx_drain", rdat, 32'(8'h10 + i));
        end
        apb_write(4'h4, 32'h40, err);
        apb_read(4'h4, rdat, err);
        chk("status_rxw1c", rdat, 32'h0000_000B);

`ifdef APB_I2C_IRQ_EN
        apb_write(4'h0, 32'h0002_0000, err);
        @(negedge clk);
        chk("irq_idle", {31'b0, irq}, 32'h0);
        rx_strobe(8'h42, 1);
        @(negedge clk);
        chk("irq_rxne", {31'b0, irq}, 32'h1);
        apb_read(4'hC, rdat, err);
        @(negedge clk);
        chk("irq_clear", {31'b0, irq}, 32'h0);
`endif

        // Asynchronous reset in the middle of a request
        apb_write(4'h8, 32'h55, err);
        apb_write(4'h0, 32'h0000_1201, err);
        chk("pre_rst_enable", {31'b0, i2c_enable}, 32'h1);
        #3 i2c_reset_n = 1'b0;
        #1;
        chk("async_rst_enable", {31'b0, i2c_enable}, 32'h0);
        chk("async_rst_data", {24'b0, i2c_data_in}, 32'h0);
        chk("async_rst_addr", {25'b0, i2c_addr}, 32'h0);
        @(negedge clk);
        i2c_reset_n = 1'b1;
        apb_read(4'h4, rdat, err);
        chk("status_after_rst", rdat, 32'h0000_000B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
